// File: rtl/cmsdk_mcu_pad_in_cond.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : cmsdk_mcu_pad_in_cond
// Description : Pad input conditioner. Two-flop synchroniser, optional per-bit
//               glitch filter with shared length, and registered single-cycle
//               rising/falling edge pulses on the filtered level.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module cmsdk_mcu_pad_in_cond #(
  parameter int               WIDTH     = 16,
  parameter int               FILT_W    = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [WIDTH-1:0]  pad_in,
  input  logic [WIDTH-1:0]  filt_en,
  input  logic [FILT_W-1:0] filt_len,
  output logic [WIDTH-1:0]  sync_out,
  output logic [WIDTH-1:0]  filt_out,
  output logic [WIDTH-1:0]  rise_pulse,
  output logic [WIDTH-1:0]  fall_pulse
);

  localparam logic [FILT_W-1:0] c_cnt_one  = {{(FILT_W-1){1'b0}}, 1'b1};
  localparam logic [FILT_W-1:0] c_cnt_zero = '0;

  logic [WIDTH-1:0]  r_s1;
  logic [WIDTH-1:0]  r_s2;
  logic [WIDTH-1:0]  r_f;
  logic [FILT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0]  r_rise;
  logic [WIDTH-1:0]  r_fall;

  logic [WIDTH-1:0]  w_f_next;
  logic [FILT_W-1:0] w_cnt_next [WIDTH];

  // Next filtered level and stability count per bit. The count only advances
  // while s2 disagrees with f; reaching the length accepts the new level. The
  // >= compare keeps the counter bounded when the length is lowered mid-count.
  always_comb begin
    w_f_next = r_f;
    for (int i = 0; i < WIDTH; i++) begin
      w_cnt_next[i] = c_cnt_zero;
      if (!filt_en[i]) begin
        w_f_next[i] = r_s2[i];
      end else if (r_s2[i] != r_f[i]) begin
        if (r_cnt[i] >= filt_len) begin
          w_f_next[i] = r_s2[i];
        end else begin
          w_cnt_next[i] = r_cnt[i] + c_cnt_one;
        end
      end
    end
  end

  // Synchroniser, filter state and edge pulses. Level flops reset to the
  // pull-up level so no edge is seen across reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_s1   <= RESET_VAL;
      r_s2   <= RESET_VAL;
      r_f    <= RESET_VAL;
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= c_cnt_zero;
      end
    end else begin
      r_s1   <= pad_in;
      r_s2   <= r_s1;
      r_f    <= w_f_next;
      r_rise <= w_f_next & ~r_f;
      r_fall <= ~w_f_next & r_f;
      for (int i = 0; i < WIDTH; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

  assign sync_out   = r_s2;
  assign filt_out   = r_f;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;

endmodule
`default_nettype wire
